ucsbece152a_input_conditioner: RTL and testbench



---
 rtl/ucsbece152a_taillights_pkg.sv | 24 ++
 rtl/ucsbece152a_debounce.sv | 77 +++++++
 rtl/ucsbece152a_input_conditioner.sv | 40 ++++
 tb/tb_ucsbece152a_input_conditioner.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ucsbece152a_taillights_pkg.sv
// Shared definitions for the taillights input path.
// Holds the switch/button channel index map, the channel count, the
// debounce length intended for real boards, and a width helper used by
// the debounce counters.
package ucsbece152a_taillights_pkg;

  // Bit positions of each raw switch/button within raw_i / level_o.
  localparam int CH_LEFT      = 0;
  localparam int CH_RIGHT     = 1;
  localparam int CH_HAZARD    = 2;
  localparam int CH_BRAKE     = 3;
  localparam int CH_RUNLIGHTS = 4;

  localparam int NUM_CH = 5;

  // Debounce length for a board clock in the tens of MHz (~10 ms of bounce).
  localparam int DEBOUNCE_CYCLES_SYNTH = 500000;

  // Counter width able to hold 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ucsbece152a_debounce.sv
// Single-channel conditioner: synchroniser chain, stability-counter
// debounce and registered edge pulses.
// Ports:
//   clk     - system clock
//   rst_n   - synchronous active-low reset
//   raw_i   - asynchronous raw switch level
//   level_o - debounced stable level
//   rise_o  - one-cycle pulse in the first cycle level_o reads 1
//   fall_o  - one-cycle pulse in the first cycle level_o reads 0
module ucsbece152a_debounce
  import ucsbece152a_taillights_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Bit 0 is the metastability-catching stage; the top bit is the synced value.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q + CNT_ONE;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (synced == stable_q) begin
      // Input agrees with the accepted level: drop any partial count so a
      // glitch shorter than the window is forgotten entirely.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // This edge is the DEBOUNCE_CYCLES-th consecutive differing sample.
      stable_d = synced;
      cnt_d    = '0;
      rise_d   = synced;
      fall_d   = ~synced;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ucsbece152a_input_conditioner.sv
// Conditions the raw taillight switches (left, right, hazard, brake,
// runlights) into clean clk-domain levels with rise/fall pulses. Each
// channel is an independent ucsbece152a_debounce instance.
// Ports:
//   clk     - system clock
//   rst_n   - synchronous active-low reset
//   raw_i   - raw switch levels, bit order from the package channel map
//   level_o - debounced levels (feed the taillights *_i inputs)
//   rise_o  - per-channel one-cycle 0->1 pulses
//   fall_o  - per-channel one-cycle 1->0 pulses
module ucsbece152a_input_conditioner #(
  parameter int NUM_CH          = ucsbece152a_taillights_pkg::NUM_CH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] raw_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o
);

  import ucsbece152a_taillights_pkg::*;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ucsbece152a_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw_i[gi]),
      .level_o(level_o[gi]),
      .rise_o (rise_o[gi]),
      .fall_o (fall_o[gi])
    );
  end

endmodule

// File: tb/tb_ucsbece152a_input_conditioner.sv
module tb_ucsbece152a_input_conditioner;
  import ucsbece152a_taillights_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [4:0] raw_i;
  logic [4:0] level_o;
  logic [4:0] rise_o;
  logic [4:0] fall_o;

  int tests;
  int failures;

  ucsbece152a_input_conditioner #(
    .NUM_CH         (5),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (raw_i),
    .level_o(level_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] el, input logic [4:0] er,
                     input logic [4:0] ef);
    tests++;
    assert (level_o === el) else begin
      failures++;
      $error("FAIL %s level_o observed=%b expected=%b", tag, level_o, el);
    end
    tests++;
    assert (rise_o === er) else begin
      failures++;
      $error("FAIL %s rise_o observed=%b expected=%b", tag, rise_o, er);
    end
    tests++;
    assert (fall_o === ef) else begin
      failures++;
      $error("FAIL %s fall_o observed=%b expected=%b", tag, fall_o, ef);
    end
    $display("[TB] t=%0t %s raw=%b level=%b rise=%b fall=%b", $time, tag, raw_i,
             level_o, rise_o, fall_o);
  endtask

  initial begin
    tests    = 0;
    failures = 0;

    // 1. Reset held 3 cycles with all raw inputs high.
    rst_n = 1'b0;
    raw_i = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", 5'b00000, 5'b00000, 5'b00000);
    end
    rst_n = 1'b1;
    raw_i = 5'b00000;
    step();
    chk("reset_release", 5'b00000, 5'b00000, 5'b00000);
    for (int i = 0; i < 3; i++) step();

    // 2. LEFT 0->1 held: level changes on the 6th edge from first sample.
    raw_i[CH_LEFT] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("left_wait", 5'b00000, 5'b00000, 5'b00000);
    end
    step();
    chk("left_rise", 5'b00001, 5'b00001, 5'b00000);
    step();
    chk("left_after", 5'b00001, 5'b00000, 5'b00000);

    // 3. BRAKE pulse of 3 cycles is rejected.
    raw_i[CH_BRAKE] = 1'b1;
    for (int i = 0; i < 3; i++) step();
    raw_i[CH_BRAKE] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("brake_glitch", 5'b00001, 5'b00000, 5'b00000);
    end

    // 4. HAZARD bounces 1,0,1,0 then held 1.
    raw_i[CH_HAZARD] = 1'b1; step();
    raw_i[CH_HAZARD] = 1'b0; step();
    raw_i[CH_HAZARD] = 1'b1; step();
    raw_i[CH_HAZARD] = 1'b0; step();
    raw_i[CH_HAZARD] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hazard_wait", 5'b00001, 5'b00000, 5'b00000);
    end
    step();
    chk("hazard_rise", 5'b00101, 5'b00100, 5'b00000);
    step();
    chk("hazard_after", 5'b00101, 5'b00000, 5'b00000);

    // Return all to 0: LEFT and HAZARD fall together.
    raw_i = 5'b00000;
    for (int i = 0; i < 5; i++) step();
    step();
    chk("clear_fall", 5'b00000, 5'b00000, 5'b00101);
    for (int i = 0; i < 3; i++) step();

    // 5. All channels rise together, then fall together.
    raw_i = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("all_wait_rise", 5'b00000, 5'b00000, 5'b00000);
    end
    step();
    chk("all_rise", 5'b11111, 5'b11111, 5'b00000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("all_high", 5'b11111, 5'b00000, 5'b00000);
    end
    raw_i = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("all_wait_fall", 5'b11111, 5'b00000, 5'b00000);
    end
    step();
    chk("all_fall", 5'b00000, 5'b00000, 5'b11111);
    step();
    chk("all_low", 5'b00000, 5'b00000, 5'b00000);
    for (int i = 0; i < 3; i++) step();

    // 6. RIGHT high, reset mid-count, released with RIGHT still high.
    raw_i[CH_RIGHT] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    chk("right_in_reset", 5'b00000, 5'b00000, 5'b00000);
    step();
    chk("right_in_reset2", 5'b00000, 5'b00000, 5'b00000);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("right_wait", 5'b00000, 5'b00000, 5'b00000);
    end
    step();
    chk("right_rise", 5'b00010, 5'b00010, 5'b00000);
    step();
    chk("right_after", 5'b00010, 5'b00000, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
